// File: rtl/tdm_pkg.sv
// Definitions shared by the TDM mux and demux: channel count, slot width
// and the framing state type.
package tdm_pkg;

    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position counter: holds the next expected slot. clear wins over
// load-to-1, which wins over advance; advancing from 3 wraps to 0.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance_i,
    input  logic              load_one_i,
    input  logic              clear_i,
    output logic [SLOT_W-1:0] slot_o
);

    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = '0;
        end else if (load_one_i) begin
            slot_d = SLOT_W'(1);
        end else if (advance_i) begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux_4.sv
// Four-channel TDM demultiplexer: aligns to the slot-0 sync flag, stages
// slots 0..2 and publishes whole frames on the slot-3 sample.
module tdm_demux_4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             out_valid,
    output logic             locked,
    output logic             sync_err
);

    state_e            state_q;
    logic [SLOT_W-1:0] slot;
    logic [WIDTH-1:0]  stage_q [NUM_CH-1];
    logic [WIDTH-1:0]  out_q   [NUM_CH];
    logic              out_valid_q;
    logic              sync_err_q;
    logic              locked_q;
    logic              cnt_advance;
    logic              cnt_load_one;
    logic              cnt_clear;

    tdm_slot_counter u_slot_counter (
        .clk        (clk),
        .rst        (rst),
        .advance_i  (cnt_advance),
        .load_one_i (cnt_load_one),
        .clear_i    (cnt_clear),
        .slot_o     (slot)
    );

    // Any accepted sync restarts the frame at slot 1; a missing sync drops
    // back to slot 0; every other valid sample in LOCKED moves on one slot.
    always_comb begin
        cnt_advance  = 1'b0;
        cnt_load_one = 1'b0;
        cnt_clear    = 1'b0;
        if (in_valid) begin
            if (in_sync) begin
                cnt_load_one = 1'b1;
            end else if (state_q == LOCKED) begin
                if (slot == '0) begin
                    cnt_clear = 1'b1;
                end else begin
                    cnt_advance = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            locked_q    <= 1'b0;
            for (int i = 0; i < NUM_CH - 1; i++) begin
                stage_q[i] <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                out_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    HUNT: begin
                        if (in_sync) begin
                            stage_q[0] <= in_data;
                            state_q    <= LOCKED;
                            locked_q   <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (in_sync) begin
                            // Early sync abandons the partial frame but keeps lock.
                            stage_q[0] <= in_data;
                            if (slot != '0) begin
                                sync_err_q <= 1'b1;
                            end
                        end else if (slot == '0) begin
                            sync_err_q <= 1'b1;
                            state_q    <= HUNT;
                            locked_q   <= 1'b0;
                        end else if (slot == SLOT_W'(NUM_CH - 1)) begin
                            for (int i = 0; i < NUM_CH - 1; i++) begin
                                out_q[i] <= stage_q[i];
                            end
                            out_q[NUM_CH-1] <= in_data;
                            out_valid_q     <= 1'b1;
                        end else begin
                            stage_q[slot] <= in_data;
                        end
                    end
                    default: begin
                        state_q <= HUNT;
                    end
                endcase
            end
        end
    end

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign out_valid = out_valid_q;
    assign locked    = locked_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_4.sv
// Self-checking bench for tdm_demux_4: directed framing scenarios followed by
// random traffic, compared each cycle against a queue-based frame model.
module tb_tdm_demux_4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sync;
    logic [7:0] out0, out1, out2, out3;
    logic       out_valid;
    logic       locked;
    logic       sync_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: a frame is "locked" plus the list of samples collected
    // since the last sync; a frame is published when that list reaches four.
    bit         m_locked;
    logic [7:0] m_frame [$];
    logic [7:0] m_out [4];
    bit         m_ov;
    bit         m_err;

    tdm_demux_4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sync   (in_sync),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out_valid (out_valid),
        .locked    (locked),
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_locked = 1'b0;
        m_frame.delete();
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
        m_ov  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_update(input bit v, input bit s, input logic [7:0] d);
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (s) begin
                m_frame.delete();
                m_frame.push_back(d);
                m_locked = 1'b1;
            end
        end else if (s) begin
            if (m_frame.size() != 0) m_err = 1'b1;
            m_frame.delete();
            m_frame.push_back(d);
        end else if (m_frame.size() == 0) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_frame.push_back(d);
            if (m_frame.size() == 4) begin
                for (int i = 0; i < 4; i++) m_out[i] = m_frame[i];
                m_ov = 1'b1;
                m_frame.delete();
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".out0"}, {24'h0, out0}, {24'h0, m_out[0]});
        check_val({tag, ".out1"}, {24'h0, out1}, {24'h0, m_out[1]});
        check_val({tag, ".out2"}, {24'h0, out2}, {24'h0, m_out[2]});
        check_val({tag, ".out3"}, {24'h0, out3}, {24'h0, m_out[3]});
        check_val({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, m_ov});
        check_val({tag, ".locked"}, {31'h0, locked}, {31'h0, m_locked});
        check_val({tag, ".sync_err"}, {31'h0, sync_err}, {31'h0, m_err});
    endtask

    task automatic step(input string tag, input bit v, input bit s, input logic [7:0] d);
        in_valid = v;
        in_sync  = s;
        in_data  = d;
        @(posedge clk);
        #1;
        model_update(v, s, d);
        check_all(tag);
        $display("step %-8s v=%0b s=%0b d=%02h -> out=%02h %02h %02h %02h ov=%0b lk=%0b err=%0b",
                 tag, v, s, d, out0, out1, out2, out3, out_valid, locked, sync_err);
    endtask

    // Reset asserted together with a valid sync sample: reset must win.
    task automatic do_reset(input string tag);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sync  = 1'b1;
        in_data  = 8'hEE;
        @(posedge clk);
        #1;
        model_reset();
        check_all(tag);
        $display("reset %-8s -> out=%02h %02h %02h %02h ov=%0b lk=%0b err=%0b",
                 tag, out0, out1, out2, out3, out_valid, locked, sync_err);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_sync  = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sync  = 1'b0;
        in_data  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset("rst0");

        // Basic frame
        step("t1", 1, 1, 8'h11);
        step("t1", 1, 0, 8'h22);
        step("t1", 1, 0, 8'h33);
        step("t1", 1, 0, 8'h44);
        check_val("t1.ov", {31'h0, out_valid}, 32'h1);
        check_val("t1.out0", {24'h0, out0}, 32'h11);
        check_val("t1.out3", {24'h0, out3}, 32'h44);
        check_val("t1.locked", {31'h0, locked}, 32'h1);
        step("t1idle", 0, 0, 8'h00);

        // Unsynced samples are dropped before lock
        do_reset("rst2");
        step("t2", 1, 0, 8'hAA);
        step("t2", 1, 0, 8'hBB);
        check_val("t2.locked", {31'h0, locked}, 32'h0);
        step("t2", 1, 1, 8'h01);
        step("t2", 1, 0, 8'h02);
        step("t2", 1, 0, 8'h03);
        step("t2", 1, 0, 8'h04);
        check_val("t2.out0", {24'h0, out0}, 32'h01);

        // Gaps in in_valid
        step("t3", 1, 1, 8'hA1);
        step("t3", 0, 0, 8'hFF);
        step("t3", 0, 1, 8'hFE);
        step("t3", 1, 0, 8'hA2);
        step("t3", 1, 0, 8'hA3);
        step("t3", 0, 0, 8'hFD);
        step("t3", 1, 0, 8'hA4);
        check_val("t3.ov", {31'h0, out_valid}, 32'h1);
        check_val("t3.out3", {24'h0, out3}, 32'hA4);

        // Early sync at slot 2
        step("t4", 1, 1, 8'hC1);
        step("t4", 1, 0, 8'hC2);
        step("t4", 1, 1, 8'h55);
        check_val("t4.err", {31'h0, sync_err}, 32'h1);
        check_val("t4.hold", {24'h0, out0}, 32'hA1);
        step("t4", 1, 0, 8'h56);
        step("t4", 1, 0, 8'h57);
        step("t4", 1, 0, 8'h58);
        check_val("t4.out0", {24'h0, out0}, 32'h55);

        // Missing sync at slot 0
        step("t5", 1, 0, 8'h99);
        check_val("t5.err", {31'h0, sync_err}, 32'h1);
        check_val("t5.locked", {31'h0, locked}, 32'h0);
        step("t5", 1, 0, 8'h9A);
        step("t5", 1, 0, 8'h9B);
        step("t5", 1, 1, 8'h9C);

        // Reset mid-frame, after slot 1
        step("t6", 1, 0, 8'h9D);
        do_reset("rst6");
        check_val("t6.out0", {24'h0, out0}, 32'h00);
        step("t6", 1, 1, 8'h61);
        step("t6", 1, 0, 8'h62);
        step("t6", 1, 0, 8'h63);
        step("t6", 1, 0, 8'h64);
        check_val("t6.out2", {24'h0, out2}, 32'h63);

        // Random traffic, mostly well-framed with occasional violations
        for (int n = 0; n < 600; n++) begin
            bit v, s, expect0;
            if ($urandom_range(0, 99) < 2) begin
                do_reset("rrst");
            end else begin
                v       = ($urandom_range(0, 3) != 0);
                expect0 = (!m_locked) || (m_frame.size() == 0);
                s       = expect0 ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 19) == 0);
                step("rand", v, s, 8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux_4.md
# tdm_demux_4

Four-channel time-division demultiplexer: the receive-side counterpart of our 4:1 channel mux. One serial stream of samples arrives one per valid cycle, with slot 0 of each frame marked by a sync flag. The block aligns to that sync, steers each sample into one of four channel slots with a 2-bit slot counter, and presents complete frames as four parallel registered words. It sits between the TDM link and the per-channel consumers.

## Interface
Parameters:
- WIDTH, 8, sample width in bits

Ports:
- clk  input  1  single clock; all logic is on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data/in_sync carry a sample this cycle
- in_data  input  WIDTH  sample
- in_sync  input  1  this sample is slot 0 of a frame; ignored when in_valid=0
- out0..out3  output  WIDTH each  registered channel words of the last complete frame
- out_valid  output  1  one-cycle pulse: out0..out3 just updated with a new frame
- locked  output  1  1 in LOCKED state
- sync_err  output  1  one-cycle pulse: framing violation detected

## Operation
- State machine has two states, HUNT and LOCKED. The slot counter (2 bits) holds the next expected slot, 0..3.
- HUNT:
  - in_valid with in_sync=0: sample discarded.
  - in_valid with in_sync=1: sample stored in staging slot 0, slot<=1, go to LOCKED.
- LOCKED, in_valid=1:
  - slot=0, in_sync=1: stage sample 0, slot<=1.
  - slot=0, in_sync=0: missing sync. Pulse sync_err, drop the sample, go to HUNT, slot<=0.
  - slot=1 or 2, in_sync=0: stage the sample at that slot, slot<=slot+1.
  - slot=3, in_sync=0: frame complete. out0..out2<=staging 0..2, out3<=in_data, out_valid pulses, slot<=0 (wrap).
  - slot 1..3, in_sync=1: early sync.
    - Pulse sync_err and discard the partial frame; out0..out3 are unchanged.
    - Take this sample as the new slot 0 and set slot<=1. State stays LOCKED.
- in_valid=0: nothing changes. Slot, state and staging hold. out_valid and sync_err are 0.
- Staging registers are internal. Outputs change only on a complete frame, so consumers never see a mixed frame.
- Reset values: out0..out3=0, out_valid=0, locked=0, sync_err=0; internally state=HUNT, slot=0, staging=0.
- rst takes priority over every other input in the same cycle. A reset mid-frame discards the partial frame.

## Timing
- All outputs are registered.
- out_valid is high in the cycle after the clock edge that accepts the slot-3 sample. out0..out3 update on that same edge.
- Latency from the slot-3 sample to out_valid is 1 cycle. Latency from the slot-0 sample is at least 4 cycles, more if in_valid has gaps.
- Back-to-back frames with in_valid held high give one out_valid pulse every 4 cycles.
- sync_err is high in the cycle after the offending sample's edge.
- locked goes high in the cycle after the accepted sync sample. It goes low in the cycle after a missing-sync sample.
- There is no backpressure: every valid sample is consumed or discarded in its own cycle.

## Structure
- Shared package tdm_pkg:
  - state enum {HUNT, LOCKED}
  - NUM_CH=4
  - SLOT_W=2
  - The package is shared with the 4:1 TDM mux side.
- One sub-module, tdm_slot_counter: a 2-bit counter with advance, load-to-1 and clear inputs and synchronous reset. The top level holds the FSM, staging and output registers.

## Test plan
- Reset, then in_valid=1 for 4 cycles with sync on the first sample and data 0x11,0x22,0x33,0x44 -> out_valid pulses once; out0..3=0x11,0x22,0x33,0x44; locked=1.
- Samples with in_sync=0 before any sync (0xAA,0xBB), then a normal frame -> the first two are dropped; out_valid fires only after the frame, with the frame's values.
- Frame with in_valid gaps (valid, idle 2 cycles, valid, valid, idle, valid) -> one out_valid, 1 cycle after the last sample, with correct data.
- Early sync at slot 2 with data 0x55 -> sync_err pulse; outputs hold the previous frame; the next 3 samples complete a frame with out0=0x55.
- Missing sync at slot 0 after a good frame -> sync_err pulse, locked drops, and subsequent samples are ignored until the next sync.
- rst asserted after slot 1 of a frame -> all outputs return to 0 and locked=0; a following full frame decodes correctly.
